game_sequencer: RTL and testbench

//  Top-level game-flow FSM for the road-crossing game. Sequences the player/car datapath:
//  - consumes one-cycle event pulses (collision, goal reached, restart) and a frame tick
//  - owns lives, the two-digit BCD level and the car speed
//  - issues respawn/freeze/car-enable controls to the player-movement and car-motion blocks.

---
 rtl/game_sequencer.sv | 131 +++++++++++++
 tb/tb_game_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-flow sequencer for the road-crossing game: owns lives, BCD level and car speed,
// and drives respawn/freeze/car-enable controls for the player and car datapaths.
module game_sequencer #(
  parameter int unsigned LIVES       = 4,
  parameter int unsigned HIT_FRAMES  = 60,
  parameter int unsigned LVL_FRAMES  = 30,
  parameter int unsigned OVER_FRAMES = 180,
  parameter int unsigned MAX_SPEED   = 31,
  parameter int unsigned BLINK_SHIFT = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collision,
  input  logic       goal,
  output logic [2:0] state,
  output logic       respawn,
  output logic       freeze,
  output logic       car_en,
  output logic [3:0] lives,
  output logic [3:0] led,
  output logic [3:0] lvl_tens,
  output logic [3:0] lvl_units,
  output logic [4:0] speed_car
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HIT   = 3'd2,
    LVLUP = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] FULL_LIVES = 4'((1 << LIVES) - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES - 1);
  localparam logic [7:0] LVL_LAST   = 8'(LVL_FRAMES - 1);
  localparam logic [7:0] OVER_LAST  = 8'(OVER_FRAMES - 1);
  localparam logic [4:0] SPEED_MAX  = 5'(MAX_SPEED);

  state_t     st;
  logic [7:0] frame_cnt;

  assign state = st;
  // Blink only while frozen after a hit or at game over.
  assign led = ((st == HIT || st == OVER) && frame_cnt[BLINK_SHIFT]) ? '0 : lives;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st        <= IDLE;
      frame_cnt <= '0;
      lives     <= FULL_LIVES;
      lvl_tens  <= '0;
      lvl_units <= '0;
      speed_car <= '0;
      respawn   <= 1'b0;
      freeze    <= 1'b1;
      car_en    <= 1'b0;
    end else begin
      respawn <= 1'b0;
      if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
      case (st)
        // IDLE and PLAY share the start path: both begin a fresh game in PLAY.
        IDLE, PLAY: begin
          if (start) begin
            st        <= PLAY;
            frame_cnt <= '0;
            lives     <= FULL_LIVES;
            lvl_tens  <= '0;
            lvl_units <= '0;
            speed_car <= '0;
            respawn   <= 1'b1;
            freeze    <= 1'b0;
            car_en    <= 1'b1;
          end else if (st == PLAY && collision) begin
            lives     <= lives >> 1;
            frame_cnt <= '0;
            freeze    <= 1'b1;
            if (lives == 4'b0001) begin
              st     <= OVER;
              car_en <= 1'b0;
            end else begin
              st <= HIT;
            end
          end else if (st == PLAY && goal) begin
            st        <= LVLUP;
            frame_cnt <= '0;
            freeze    <= 1'b1;
            car_en    <= 1'b0;
            if (lvl_units != 4'd9) begin
              lvl_units <= lvl_units + 4'd1;
            end else if (lvl_tens != 4'd9) begin
              lvl_units <= '0;
              lvl_tens  <= lvl_tens + 4'd1;
            end
            if (speed_car < SPEED_MAX) speed_car <= speed_car + 5'd1;
          end
        end
        HIT, LVLUP: begin
          if (frame_tick && frame_cnt == ((st == HIT) ? HIT_LAST : LVL_LAST)) begin
            st        <= PLAY;
            frame_cnt <= '0;
            respawn   <= 1'b1;
            freeze    <= 1'b0;
            car_en    <= 1'b1;
          end
        end
        OVER: begin
          if (start || (frame_tick && frame_cnt == OVER_LAST)) begin
            st        <= IDLE;
            frame_cnt <= '0;
            lives     <= FULL_LIVES;
            lvl_tens  <= '0;
            lvl_units <= '0;
            speed_car <= '0;
            freeze    <= 1'b1;
            car_en    <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          frame_cnt <= '0;
          freeze    <= 1'b1;
          car_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a game-level model (life count, decimal level,
// ticks since entry) is checked every cycle, plus literal expectations at key points.
module tb_game_sequencer;
  localparam int unsigned HF = 3;
  localparam int unsigned LF = 2;
  localparam int unsigned OF = 5;
  localparam int unsigned MS = 31;
  localparam int unsigned BS = 1;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, collision = 1'b0, goal = 1'b0;
  logic [2:0] state;
  logic       respawn, freeze, car_en;
  logic [3:0] lives, led, lvl_tens, lvl_units;
  logic [4:0] speed_car;

  game_sequencer #(
    .LIVES(4), .HIT_FRAMES(HF), .LVL_FRAMES(LF), .OVER_FRAMES(OF),
    .MAX_SPEED(MS), .BLINK_SHIFT(BS)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick), .start(start),
    .collision(collision), .goal(goal), .state(state), .respawn(respawn),
    .freeze(freeze), .car_en(car_en), .lives(lives), .led(led),
    .lvl_tens(lvl_tens), .lvl_units(lvl_units), .speed_car(speed_car)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state code, number of lives left, level 0..99, speed, ticks since state entry.
  int m_state = 0, m_nlives = 4, m_level = 0, m_speed = 0, m_cnt = 0;
  bit m_respawn = 1'b0;
  bit m_enter;

  task new_game;
    m_nlives = 4;
    m_level  = 0;
    m_speed  = 0;
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_state = 0; m_cnt = 0; m_respawn = 1'b0;
      new_game();
    end else begin
      m_enter   = 1'b0;
      m_respawn = 1'b0;
      case (m_state)
        0: if (start) begin new_game(); m_state = 1; m_enter = 1; m_respawn = 1; end
        1: begin
          if (start) begin
            new_game(); m_enter = 1; m_respawn = 1;
          end else if (collision) begin
            m_nlives = m_nlives - 1;
            m_state  = (m_nlives == 0) ? 4 : 2;
            m_enter  = 1;
          end else if (goal) begin
            if (m_level < 99) m_level = m_level + 1;
            if (m_speed < int'(MS)) m_speed = m_speed + 1;
            m_state = 3;
            m_enter = 1;
          end
        end
        2: if (frame_tick && m_cnt + 1 == int'(HF)) begin m_state = 1; m_enter = 1; m_respawn = 1; end
        3: if (frame_tick && m_cnt + 1 == int'(LF)) begin m_state = 1; m_enter = 1; m_respawn = 1; end
        4: if (start || (frame_tick && m_cnt + 1 == int'(OF))) begin new_game(); m_state = 0; m_enter = 1; end
        default: ;
      endcase
      if (m_enter) m_cnt = 0;
      else if (frame_tick) m_cnt = m_cnt + 1;
    end
  end

  initial forever begin
    int therm;
    bit blank;
    @(negedge CLK);
    if (cmp_en) begin
      therm = (1 << m_nlives) - 1;
      blank = (m_state == 2 || m_state == 4) && (((m_cnt >> BS) & 1) == 1);
      chk("state",   32'(state),     32'(m_state));
      chk("respawn", 32'(respawn),   32'(m_respawn));
      chk("freeze",  32'(freeze),    32'(m_state != 1));
      chk("car_en",  32'(car_en),    32'(m_state == 1 || m_state == 2));
      chk("lives",   32'(lives),     32'(therm));
      chk("led",     32'(led),       blank ? 32'd0 : 32'(therm));
      chk("tens",    32'(lvl_tens),  32'(m_level / 10));
      chk("units",   32'(lvl_units), 32'(m_level % 10));
      chk("speed",   32'(speed_car), 32'(m_speed));
    end
  end

  // Called at posedge+1; applies inputs for exactly one clock edge.
  task automatic step(input logic s, input logic c, input logic g, input logic t);
    start = s; collision = c; goal = g; frame_tick = t;
    @(posedge CLK); #1;
    start = 1'b0; collision = 1'b0; goal = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [3:0] exp_l  [4];
    logic [2:0] exp_st [4];
    exp_l  = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    exp_st = '{3'd2, 3'd2, 3'd2, 3'd4};

    repeat (3) @(posedge CLK);
    #1;
    cmp_en = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_freeze", 32'(freeze), 1);
    chk("rst_lives", 32'(lives), 15);
    chk("rst_led", 32'(led), 15);
    chk("rst_speed", 32'(speed_car), 0);
    RST_N = 1'b1;
    step(0, 0, 0, 0);

    // 1: start into PLAY
    step(1, 0, 0, 0);
    chk("t1_state", 32'(state), 1);
    chk("t1_respawn", 32'(respawn), 1);
    chk("t1_freeze", 32'(freeze), 0);
    chk("t1_car_en", 32'(car_en), 1);
    step(0, 0, 0, 0);
    chk("t1_respawn_off", 32'(respawn), 0);

    // 2: four collisions, then game over timeout
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      chk("t2_lives", 32'(lives), 32'(exp_l[i]));
      chk("t2_state", 32'(state), 32'(exp_st[i]));
      if (i < 3) begin
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        ticks(HF);
        chk("t2_back_play", 32'(state), 1);
      end
    end
    chk("t2_over_car_en", 32'(car_en), 0);
    ticks(OF);
    chk("t2_idle", 32'(state), 0);
    chk("t2_idle_lives", 32'(lives), 15);

    // 3: ten level-ups
    step(1, 0, 0, 0);
    for (int g = 1; g <= 10; g++) begin
      step(0, 0, 1, 0);
      chk("t3_state", 32'(state), 3);
      chk("t3_car_en", 32'(car_en), 0);
      if (g == 1) step(1, 0, 0, 0);
      ticks(LF);
      if (g == 9) begin
        chk("t3_tens9", 32'(lvl_tens), 0);
        chk("t3_units9", 32'(lvl_units), 9);
      end
    end
    chk("t3_tens10", 32'(lvl_tens), 1);
    chk("t3_units10", 32'(lvl_units), 0);
    chk("t3_speed10", 32'(speed_car), 10);

    // 4: climb to 99 and saturate
    for (int g = 11; g <= 99; g++) begin
      step(0, 0, 1, 0);
      ticks(LF);
    end
    chk("t4_tens", 32'(lvl_tens), 9);
    chk("t4_units", 32'(lvl_units), 9);
    chk("t4_speed", 32'(speed_car), 31);
    step(0, 0, 1, 0);
    chk("t4_sat_state", 32'(state), 3);
    chk("t4_sat_units", 32'(lvl_units), 9);
    chk("t4_sat_speed", 32'(speed_car), 31);
    ticks(LF);

    // 5: priority cases
    step(0, 1, 1, 0);
    chk("t5_state", 32'(state), 2);
    chk("t5_lives", 32'(lives), 7);
    chk("t5_tens", 32'(lvl_tens), 9);
    ticks(HF);
    step(1, 1, 0, 0);
    chk("t5_restart_state", 32'(state), 1);
    chk("t5_restart_lives", 32'(lives), 15);
    chk("t5_restart_units", 32'(lvl_units), 0);
    chk("t5_restart_speed", 32'(speed_car), 0);
    chk("t5_restart_respawn", 32'(respawn), 1);

    // 6: async reset mid-HIT
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_state", 32'(state), 0);
    chk("t6_freeze", 32'(freeze), 1);
    chk("t6_lives", 32'(lives), 15);
    chk("t6_car_en", 32'(car_en), 0);
    chk("t6_led", 32'(led), 15);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    step(0, 1, 0, 0);
    chk("t6_idle_hold", 32'(state), 0);
    chk("t6_idle_lives", 32'(lives), 15);

    // 7: start aborts game over
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      if (i < 3) ticks(HF);
    end
    chk("t7_over", 32'(state), 4);
    step(1, 0, 0, 0);
    chk("t7_idle", 32'(state), 0);
    chk("t7_lives", 32'(lives), 15);
    step(1, 0, 0, 0);
    chk("t7_play", 32'(state), 1);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
